// File: rtl/pack_rq0.sv
// ---------------------------------------------------------------------------
// pack_rq0 -- serialises a parallel polynomial into two-coefficient beats.
//
// A load in IDLE captures coefficients 0..N-2 of h_in into a shift register.
// The register then streams out as (N-1)/2 beats of {even, odd} coefficient
// pairs over a valid/ready handshake. Coefficient N-1 never reaches the
// outputs.
//
// Optional feature (macro PACK_RQ0_SUMCHK_EN): a 13-bit accumulator starts
// with coefficient N-1 and adds every transferred coefficient modulo 8192.
// sum_err reports a nonzero total from the DONE cycle until the next load or
// reset. With the macro undefined, sum_err is tied to 0.
//
// Ports
//   clk        in   clock, rising edge
//   ovr_rst    in   asynchronous active-high reset
//   load       in   start pulse, honoured only in IDLE
//   h_in       in   [H_BITS:1]; coefficient i = bits [13*i+13 : 13*i+1]
//   out_ready  in   downstream accepts the current beat
//   even_out   out  coefficient 2k of beat k (0 when out_valid=0)
//   odd_out    out  coefficient 2k+1 of beat k (0 when out_valid=0)
//   out_valid  out  beat presented (SHIFT state)
//   busy       out  high in SHIFT and DONE
//   done       out  one-cycle pulse after the final beat transfers
//   sum_err    out  sum-zero check result
// ---------------------------------------------------------------------------
module pack_rq0 #(
  parameter int H_BITS = 9113,
  parameter int N      = 701
) (
  input  logic            clk,
  input  logic            ovr_rst,
  input  logic            load,
  input  logic [H_BITS:1] h_in,
  input  logic            out_ready,
  output logic [12:0]     even_out,
  output logic [12:0]     odd_out,
  output logic            out_valid,
  output logic            busy,
  output logic            done,
  output logic            sum_err
);

  localparam int         SR_W  = H_BITS - 13;
  localparam int         BEATS = (N - 1) / 2;
  localparam logic [8:0] LAST  = 9'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [SR_W:1]   shift_reg;
  logic [8:0]      beat_cnt_reg;
  logic            xfer;
  logic            start;

  assign start = (state_reg == IDLE) && load;
  assign xfer  = (state_reg == SHIFT) && out_ready;

  // State register
  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (xfer && (beat_cnt_reg == LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on start, consume one coefficient pair per transfer.
  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      shift_reg    <= '0;
      beat_cnt_reg <= '0;
    end else if (start) begin
      shift_reg    <= h_in[H_BITS-13:1];
      beat_cnt_reg <= '0;
    end else if (xfer) begin
      shift_reg    <= shift_reg >> 26;
      beat_cnt_reg <= beat_cnt_reg + 9'd1;
    end
  end

  // Outputs decode straight from state, so reset clears them without waiting
  // for a clock edge.
  always_comb begin
    out_valid = (state_reg == SHIFT);
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    even_out  = out_valid ? shift_reg[13:1]  : 13'd0;
    odd_out   = out_valid ? shift_reg[26:14] : 13'd0;
  end

`ifdef PACK_RQ0_SUMCHK_EN
  logic [12:0] acc_reg;
  logic [12:0] acc_sum;
  logic        sum_err_reg;

  // 13-bit addition wraps naturally modulo 8192.
  assign acc_sum = acc_reg + shift_reg[13:1] + shift_reg[26:14];

  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      acc_reg     <= '0;
      sum_err_reg <= 1'b0;
    end else if (start) begin
      acc_reg     <= h_in[H_BITS:H_BITS-12];
      sum_err_reg <= 1'b0;
    end else if (xfer) begin
      acc_reg <= acc_sum;
      // Resolve on the final transfer so the result is visible in DONE.
      if (beat_cnt_reg == LAST) sum_err_reg <= (acc_sum != 13'd0);
    end
  end

  assign sum_err = sum_err_reg;
`else
  // The top coefficient is only consumed by the checksum.
  logic unused_coef_top;
  assign unused_coef_top = ^h_in[H_BITS:H_BITS-12];
  assign sum_err         = 1'b0;
`endif

endmodule

// File: tb/tb_pack_rq0.sv
// ---------------------------------------------------------------------------
// tb_pack_rq0 -- directed self-checking bench for pack_rq0.
// Builds coefficient tables, drives them through h_in and checks every beat,
// the done pulse, busy, reset abort, held load and (when enabled) the
// checksum.
// ---------------------------------------------------------------------------
module tb_pack_rq0;
  localparam int H_BITS = 9113;
  localparam int N      = 701;

  logic            clk = 1'b0;
  logic            ovr_rst;
  logic            load;
  logic [H_BITS:1] h_in;
  logic            out_ready;
  logic [12:0]     even_out;
  logic [12:0]     odd_out;
  logic            out_valid;
  logic            busy;
  logic            done;
  logic            sum_err;

  int          checks = 0;
  int          errors = 0;
  logic [12:0] coefs [0:N-1];
  logic        exp_se;

  pack_rq0 #(.H_BITS(H_BITS), .N(N)) dut (
    .clk       (clk),
    .ovr_rst   (ovr_rst),
    .load      (load),
    .h_in      (h_in),
    .out_ready (out_ready),
    .even_out  (even_out),
    .odd_out   (odd_out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .sum_err   (sum_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // mode 0: coef i = i, mode 1: coef i = 699-i, mode 2: coef i = 1
  task automatic set_pattern(input int mode, input logic [12:0] c_top);
    int sum;
    sum = 0;
    for (int i = 0; i < N - 1; i++) begin
      case (mode)
        0:       coefs[i] = 13'(i);
        1:       coefs[i] = 13'(N - 2 - i);
        default: coefs[i] = 13'd1;
      endcase
      sum += int'(coefs[i]);
    end
    coefs[N-1] = c_top;
    sum += int'(c_top);
    for (int i = 0; i < N; i++) h_in[13*i+1 +: 13] = coefs[i];
`ifdef PACK_RQ0_SUMCHK_EN
    exp_se = ((sum % 8192) != 0);
`else
    exp_se = 1'b0;
`endif
  endtask

  // Starts from a negedge in IDLE. ready_mode 0 = always ready, 1 = toggling.
  // abort_at >= 0 pulses reset while that beat is presented.
  task automatic run_stream(input int ready_mode, input int abort_at, input bit hold_load);
    int k;
    int cyc;
    bit rdy;
    k   = 0;
    cyc = 0;
    load = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!hold_load) load = 1'b0;
    while (k < (N - 1) / 2 && cyc < 3000) begin
      if (k == abort_at) begin
        #2 ovr_rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_even",  32'(even_out),  32'd0);
        chk("rst_odd",   32'(odd_out),   32'd0);
        chk("rst_done",  32'(done),      32'd0);
        @(negedge clk);
        ovr_rst = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("post_rst_valid", 32'(out_valid), 32'd0);
          chk("post_rst_busy",  32'(busy),      32'd0);
        end
        return;
      end
      rdy = (ready_mode == 0) || (cyc % 2 == 0);
      out_ready = rdy;
      chk("beat_valid", 32'(out_valid), 32'd1);
      chk($sformatf("even_b%0d", k), 32'(even_out), 32'(coefs[2*k]));
      chk($sformatf("odd_b%0d", k),  32'(odd_out),  32'(coefs[2*k+1]));
      @(posedge clk); @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    chk("beat_count", 32'(k), 32'd350);
    chk("done_pulse",  32'(done),      32'd1);
    chk("done_valid",  32'(out_valid), 32'd0);
    chk("done_busy",   32'(busy),      32'd1);
    chk("done_even",   32'(even_out),  32'd0);
    chk("done_odd",    32'(odd_out),   32'd0);
    chk("done_sumerr", 32'(sum_err),   32'(exp_se));
    @(posedge clk); @(negedge clk);
    chk("idle_busy",   32'(busy),      32'd0);
    chk("idle_done",   32'(done),      32'd0);
    chk("idle_valid",  32'(out_valid), 32'd0);
    chk("idle_sumerr", 32'(sum_err),   32'(exp_se));
    $display("stream ready_mode=%0d hold_load=%0d beats=%0d cycles=%0d", ready_mode, hold_load, k, cyc);
  endtask

  initial begin
    ovr_rst   = 1'b1;
    load      = 1'b0;
    out_ready = 1'b0;
    h_in      = '0;
    exp_se    = 1'b0;
    #12;
    chk("reset_valid",  32'(out_valid), 32'd0);
    chk("reset_busy",   32'(busy),      32'd0);
    chk("reset_done",   32'(done),      32'd0);
    chk("reset_sumerr", 32'(sum_err),   32'd0);
    chk("reset_even",   32'(even_out),  32'd0);
    chk("reset_odd",    32'(odd_out),   32'd0);
    @(negedge clk);
    ovr_rst = 1'b0;
    @(negedge clk);

    // Ramp, always ready
    set_pattern(0, 13'd0);
    run_stream(0, -1, 1'b0);

    // Ramp, ready toggling: beats must hold through stalls
    run_stream(1, -1, 1'b0);

    // Reset during beat 100, then restart with reversed data and a loud top coef
    set_pattern(0, 13'd0);
    run_stream(0, 100, 1'b0);
    set_pattern(1, 13'h1ABC);
    run_stream(0, -1, 1'b0);

    // Load held high throughout: one transfer, then restart from IDLE
    set_pattern(0, 13'h1FFF);
    run_stream(0, -1, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("reload_valid", 32'(out_valid), 32'd1);
    chk("reload_even",  32'(even_out),  32'(coefs[0]));
    chk("reload_odd",   32'(odd_out),   32'(coefs[1]));
    load = 1'b0;
    $display("held load restart observed valid=%0d even=%0d odd=%0d", out_valid, even_out, odd_out);
    ovr_rst = 1'b1;
    @(negedge clk);
    ovr_rst = 1'b0;
    @(negedge clk);

`ifdef PACK_RQ0_SUMCHK_EN
    set_pattern(2, 13'h1D44);
    chk("model_sum_zero", 32'(exp_se), 32'd0);
    run_stream(0, -1, 1'b0);
    set_pattern(2, 13'h1D45);
    run_stream(0, -1, 1'b0);
    chk("sumerr_set", 32'(sum_err), 32'd1);
`else
    set_pattern(2, 13'h1D45);
    run_stream(0, -1, 1'b0);
    chk("sumerr_tied", 32'(sum_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pack_rq0.md
PACK_RQ0 -- requirements
Module: pack_rq0

Interface
REQ-001 Parameter H_BITS, default 9113, width in bits of the parallel polynomial (701 coefficients of 13 bits).
REQ-002 Parameter N, default 701, coefficient count; the packed stream carries N-1 = 700 coefficients.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 ovr_rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  start pulse; samples h_in.
REQ-006 h_in  input  [H_BITS:1]  polynomial; coefficient i occupies bits [13*i+13 : 13*i+1].
REQ-007 out_ready  input  1  downstream accepts current beat.
REQ-008 even_out  output  [12:0]  coefficient 2k of beat k.
REQ-009 odd_out  output  [12:0]  coefficient 2k+1 of beat k.
REQ-010 out_valid  output  1  beat k presented.
REQ-011 busy  output  1  high outside IDLE.
REQ-012 done  output  1  one-cycle pulse after the final beat is accepted.
REQ-013 sum_err  output  1  sum-zero check result (see Configuration).

Function
REQ-014 FSM states IDLE, SHIFT, DONE; the block SHALL power up and reset into IDLE.
REQ-015 IDLE: on load=1 the block SHALL copy h_in[H_BITS-13:1] into a 9100-bit shift register, clear the 9-bit beat counter and enter SHIFT next cycle.
REQ-016 Latency: load sampled at edge t SHALL produce out_valid=1 after edge t, i.e. beat 0 is presented in the following cycle.
REQ-017 SHIFT: out_valid=1; even_out = shift[13:1], odd_out = shift[26:14].
REQ-018 Handshake: a beat transfers only on a clock edge with out_valid=1 and out_ready=1; on transfer the shift register SHALL shift right by 26 bits and the beat counter SHALL increment.
REQ-019 While out_valid=1 and out_ready=0, even_out and odd_out SHALL hold stable.
REQ-020 Transfer of beat 349 SHALL move the FSM to DONE; exactly 350 beats are emitted per load.
REQ-021 DONE: done=1, out_valid=0 for exactly one cycle, then IDLE.
REQ-022 Coefficient 700 (h_in[9113:9101]) SHALL never appear on the outputs.
REQ-023 even_out and odd_out SHALL be 0 whenever out_valid=0.
REQ-024 load asserted in SHIFT or DONE SHALL be ignored; no restart, no data corruption.
REQ-025 load asserted in the same cycle the FSM returns from DONE to IDLE is ignored; load is honoured only when sampled in IDLE.
REQ-026 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.

Reset
REQ-027 ovr_rst=1 SHALL immediately force IDLE, clear the shift register, beat counter and checksum accumulator, and drive out_valid, busy, done, sum_err, even_out, odd_out to 0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the transfer; after release no beat is emitted until a new load.

Configuration
REQ-029 Macro PACK_RQ0_SUMCHK_EN defined: a 13-bit accumulator SHALL be loaded with coefficient 700 at load, add both coefficients of every transferred beat modulo 8192, and in DONE sum_err SHALL be 1 if the total is nonzero, else 0; sum_err SHALL hold its value until the next load or reset.
REQ-030 Macro undefined: no accumulator is built and sum_err SHALL be tied to 0.

Verification
REQ-031 Coefficient i = i (i=0..699) and coefficient 700 = 0, out_ready=1 -> beats k=0..349 with even_out=2k, odd_out=2k+1 on consecutive cycles; done in the cycle after beat 349; total 352 cycles from load to IDLE.
REQ-032 Same input, out_ready toggling 1,0,1,0 -> each beat held unchanged across stall cycles; still exactly 350 transfers, values in order.
REQ-033 With PACK_RQ0_SUMCHK_EN: coefficients 0..699 = 1, coefficient 700 = 0x1D44 (8192-700) -> sum_err=0; change coefficient 700 to 0x1D45 -> sum_err=1.
REQ-034 ovr_rst pulsed during beat 100 -> all outputs 0 immediately; no further beats; a new load restarts at beat 0 with new data.
REQ-035 load held high throughout a transfer -> exactly one 350-beat transfer; a second transfer starts only after IDLE is reached with load still high.
